// File: rtl/clock_logic_delay_sched.sv
// rtl/clock_logic_delay_sched.sv - round-robin scheduler sharing one pulse delay line
// Completion slots are reserved at grant time so at most one delayed pulse finishes per cycle.
module clock_logic_delay_sched #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 8,
  parameter int TAP_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*TAP_W-1:0]   req_tap_i,
  output logic [N_REQ-1:0]         req_ack_o,
  output logic [N_REQ-1:0]         req_err_o,
  output logic                     done_valid_o,
  output logic [ID_W-1:0]          done_id_o,
  output logic [DEPTH-1:0]         line_out_o,
  output logic                     busy_o
);

  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // resv bit k-1 holds resv[k]: a completion is due k cycles from now
  logic [DEPTH-1:0] resv_q, resv_d;
  logic [ID_W-1:0]  slot_q [DEPTH];
  logic [ID_W-1:0]  slot_d [DEPTH];
  logic [DEPTH-1:0] line_q, line_d;
  logic             done_valid_q, done_valid_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [ID_W-1:0]  rr_q, rr_d;

  logic [N_REQ-1:0] legal;
  logic [N_REQ-1:0] elig;
  logic             ack_any;
  logic [ID_W-1:0]  win_id;
  logic [TAP_W-1:0] win_tap;

  always_comb begin
    logic [TAP_W-1:0] tap;
    logic [DW-1:0]    tidx;
    legal = '0;
    elig  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tap      = req_tap_i[i*TAP_W +: TAP_W];
      tidx     = DW'(tap - TAP_W'(1));
      legal[i] = (tap != '0) && (tap <= TAP_W'(DEPTH));
      elig[i]  = req_i[i] && legal[i] && !resv_q[tidx];
    end
  end

  assign req_err_o = req_i & ~legal;

  always_comb begin
    logic [ID_W-1:0] idx;
    ack_any   = 1'b0;
    win_id    = '0;
    win_tap   = '0;
    req_ack_o = '0;
    for (int o = 0; o < N_REQ; o++) begin
      idx = ID_W'((int'(rr_q) + o) % N_REQ);
      if (!ack_any && elig[idx]) begin
        ack_any = 1'b1;
        win_id  = idx;
        win_tap = req_tap_i[idx*TAP_W +: TAP_W];
      end
    end
    if (ack_any) req_ack_o[win_id] = 1'b1;
  end

  always_comb begin
    logic [DW-1:0] t;
    resv_d       = {1'b0, resv_q[DEPTH-1:1]};
    for (int j = 0; j < DEPTH - 1; j++) slot_d[j] = slot_q[j+1];
    slot_d[DEPTH-1] = '0;
    done_valid_d = resv_q[0];
    done_id_d    = slot_q[0];
    line_d       = {line_q[DEPTH-2:0], ack_any};
    rr_d         = rr_q;
    t            = DW'(win_tap - TAP_W'(2));
    if (ack_any) begin
      // Tap 1 completes on the very next cycle, bypassing the reservation map
      if (win_tap == TAP_W'(1)) begin
        done_valid_d = 1'b1;
        done_id_d    = win_id;
      end else begin
        resv_d[t] = 1'b1;
        slot_d[t] = win_id;
      end
      rr_d = ID_W'((int'(win_id) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      resv_q       <= '0;
      line_q       <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      rr_q         <= '0;
      for (int j = 0; j < DEPTH; j++) slot_q[j] <= '0;
    end else begin
      resv_q       <= resv_d;
      line_q       <= line_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      rr_q         <= rr_d;
      for (int j = 0; j < DEPTH; j++) slot_q[j] <= slot_d[j];
    end
  end

  assign done_valid_o = done_valid_q;
  assign done_id_o    = done_id_q;
  assign line_out_o   = line_q;
  assign busy_o       = (|resv_q) | (|line_q);

endmodule
